tx_byte_scrambler: RTL and testbench

- Gen1/Gen2 (8b/10b) transmit scrambler. Sits directly downstream of the ordered-set/LTSSM generator and the TLP/DLLP mux, and upstream of the 8b/10b encoder / PHY TX.
- Consumes a multi-lane AXI-Stream in which each byte carries a K-flag on tuser.
- Holds one 16-bit LFSR per lane and scrambles D-symbols per PCIe rules.
- Output is a single registered pipeline stage.

---
 rtl/tx_byte_scrambler_if.sv | 26 ++
 rtl/tx_byte_scrambler.sv | 140 ++++++++++++++
 tb/tb_tx_byte_scrambler.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_byte_scrambler_if.sv
`default_nettype none
// ============================================================================
//  Module      : tx_byte_scrambler_if
//  Description : Multi-lane AXI-Stream bundle used on both sides of the
//                transmit scrambler. Each byte of tdata has a matching
//                tkeep bit and a tuser bit (1 = K-symbol).
//  Ports       : tdata/tkeep/tuser/tvalid/tlast driven by the master,
//                tready driven by the slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tx_byte_scrambler_if #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = 16,
  parameter int USER_W = 16
) ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic [USER_W-1:0] tuser;
  logic              tvalid;
  logic              tlast;
  logic              tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/tx_byte_scrambler.sv
`default_nettype none
// ============================================================================
//  Module      : tx_byte_scrambler
//  Description : Gen1/Gen2 (8b/10b) transmit scrambler. One 16-bit Galois
//                LFSR (X^16+X^5+X^4+X^3+1) per lane; D-symbols are XORed
//                with the key unless inside an ordered set or disabled.
//                COM reseeds the lane, SKP leaves it untouched. A single
//                registered output stage with full-throughput handshake.
//  Ports       : clk_i          - clock
//                rst_ni         - asynchronous active-low reset
//                scramble_dis_i - 1 = pass data raw (LFSRs still advance)
//                s_axis         - input stream (slave modport)
//                m_axis         - output stream (master modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_byte_scrambler #(
  parameter int MAX_NUM_LANES = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int KEEP_WIDTH    = DATA_WIDTH/8,
  parameter int USER_WIDTH    = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                scramble_dis_i,
  tx_byte_scrambler_if.slave  s_axis,
  tx_byte_scrambler_if.master m_axis
);

  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [15:0] LFSR_TAPS = 16'h0039;
  localparam logic [7:0]  SYM_COM   = 8'hBC;
  localparam logic [7:0]  SYM_SKP   = 8'h1C;
  localparam int          TOT_DATA  = DATA_WIDTH*MAX_NUM_LANES;
  localparam int          TOT_KEEP  = KEEP_WIDTH*MAX_NUM_LANES;
  localparam int          TOT_USER  = USER_WIDTH*MAX_NUM_LANES;

  // Eight serial shifts: returns {key byte, next LFSR state}. Key bit i is
  // the bit shifted out on the i-th shift.
  function automatic logic [23:0] advance8(input logic [15:0] seed);
    logic [15:0] st;
    logic [7:0]  key;
    st  = seed;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      key[i] = st[15];
      st     = {st[14:0], 1'b0} ^ (st[15] ? LFSR_TAPS : 16'h0000);
    end
    return {key, st};
  endfunction

  logic                accept;
  logic [TOT_DATA-1:0] data_nxt;
  logic                out_valid;
  logic [TOT_DATA-1:0] out_data;
  logic [TOT_KEEP-1:0] out_keep;
  logic [TOT_USER-1:0] out_user;
  logic                out_last;

  // The output register can load whenever it is empty or being drained.
  assign s_axis.tready = !out_valid || m_axis.tready;
  assign accept        = s_axis.tvalid && s_axis.tready;

  for (genvar l = 0; l < MAX_NUM_LANES; l++) begin : g_lane
    logic [15:0]           lfsr;
    logic                  in_os;
    logic [15:0]           lfsr_nxt;
    logic                  in_os_nxt;
    logic [DATA_WIDTH-1:0] lane_data;

    // Bytes are chained in order so a COM early in the beat reseeds the
    // LFSR and sets in_os for the bytes that follow it in the same beat.
    always_comb begin
      logic [15:0] st;
      logic        os;
      logic [7:0]  byte_in;
      logic [23:0] adv;
      logic        is_k;
      st        = lfsr;
      os        = in_os;
      lane_data = s_axis.tdata[DATA_WIDTH*l +: DATA_WIDTH];
      for (int b = 0; b < KEEP_WIDTH; b++) begin
        byte_in = s_axis.tdata[DATA_WIDTH*l + 8*b +: 8];
        is_k    = s_axis.tuser[USER_WIDTH*l + b];
        adv     = advance8(st);
        if (s_axis.tkeep[KEEP_WIDTH*l + b]) begin
          if (is_k && byte_in == SYM_COM) begin
            st = LFSR_SEED;
            os = 1'b1;
          end else if (!(is_k && byte_in == SYM_SKP)) begin
            if (!is_k && !os && !scramble_dis_i) begin
              lane_data[8*b +: 8] = byte_in ^ adv[23:16];
            end
            st = adv[15:0];
          end
        end
      end
      lfsr_nxt  = st;
      // tlast closes the ordered set for the following beat.
      in_os_nxt = s_axis.tlast ? 1'b0 : os;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        lfsr  <= LFSR_SEED;
        in_os <= 1'b0;
      end else if (accept) begin
        lfsr  <= lfsr_nxt;
        in_os <= in_os_nxt;
      end
    end

    assign data_nxt[DATA_WIDTH*l +: DATA_WIDTH] = lane_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_user  <= '0;
      out_last  <= 1'b0;
    end else if (s_axis.tready) begin
      out_valid <= s_axis.tvalid;
      if (s_axis.tvalid) begin
        out_data <= data_nxt;
        out_keep <= s_axis.tkeep;
        out_user <= s_axis.tuser;
        out_last <= s_axis.tlast;
      end
    end
  end

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tkeep  = out_keep;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;

endmodule
`default_nettype wire

// File: tb/tb_tx_byte_scrambler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_byte_scrambler
//  Description : Self-checking bench for tx_byte_scrambler with a polynomial
//                reference model of the per-lane scrambling rules.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tx_byte_scrambler;
  localparam int NL = 4;
  localparam int TW = 128;
  localparam int TK = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dis = 1'b0;
  always #5 clk = ~clk;

  tx_byte_scrambler_if #(.DATA_W(TW), .KEEP_W(TK), .USER_W(TK)) s_if ();
  tx_byte_scrambler_if #(.DATA_W(TW), .KEEP_W(TK), .USER_W(TK)) m_if ();

  tx_byte_scrambler #(.MAX_NUM_LANES(4), .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .scramble_dis_i(dis), .s_axis(s_if), .m_axis(m_if));

  typedef struct packed {
    logic [TW-1:0] data; logic [TK-1:0] keep; logic [TK-1:0] user; logic last; logic dis;
  } beat_t;
  typedef struct packed {
    logic [TW-1:0] data; logic [TK-1:0] keep; logic [TK-1:0] user; logic last;
  } out_t;

  beat_t in_q[$];
  out_t  exp_q[$];
  out_t  obs[$];
  int total = 0;
  int bad = 0;
  int rdy_bad, rdy_low;
  int unsigned ref_lfsr[NL];
  bit ref_os[NL];

  // Reference model: LFSR state as a polynomial, each shift multiplies by x
  // modulo G(x) = 0x10039; the coefficient leaving x^15 is the key bit.
  task automatic model_push(input beat_t bt);
    out_t o;
    o.data = bt.data; o.keep = bt.keep; o.user = bt.user; o.last = bt.last;
    for (int l = 0; l < NL; l++) begin
      bit os = ref_os[l];
      int unsigned v = ref_lfsr[l];
      for (int b = 0; b < 4; b++) begin
        int p = l*32 + b*8;
        logic [7:0] sym = bt.data[p +: 8];
        bit k = bt.user[l*4+b];
        if (!bt.keep[l*4+b]) continue;
        if (k && sym == 8'hBC) begin
          v = 32'hFFFF; os = 1;
        end else if (!(k && sym == 8'h1C)) begin
          logic [7:0] key = 0;
          for (int i = 0; i < 8; i++) begin
            v = v << 1;
            key[i] = v[16];
            if (v[16]) v = v ^ 32'h10039;
          end
          if (!k && !os && !bt.dis) o.data[p +: 8] = sym ^ key;
        end
      end
      ref_lfsr[l] = v;
      ref_os[l] = bt.last ? 1'b0 : os;
    end
    exp_q.push_back(o);
  endtask

  task automatic do_reset(input bit rdy);
    rst_n = 1'b0; dis = 1'b0; s_if.tvalid = 1'b0; m_if.tready = rdy;
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int l = 0; l < NL; l++) begin ref_lfsr[l] = 32'hFFFF; ref_os[l] = 0; end
    exp_q.delete();
  endtask

  // Drives in_q with random valid/ready gaps plus an optional forced stall,
  // recording every beat taken at the output into obs.
  task automatic run_stream(input int vprob, input int rprob, input int stall_at,
                            input int stall_len, output bit timeout);
    int idx = 0;
    int cyc = 0;
    obs.delete(); exp_q.delete(); rdy_bad = 0; rdy_low = 0; timeout = 0;
    while (obs.size() < in_q.size()) begin
      if (cyc > 5000) begin timeout = 1; break; end
      if (idx < in_q.size() && $urandom_range(99) < vprob) begin
        s_if.tvalid = 1'b1; s_if.tdata = in_q[idx].data; s_if.tkeep = in_q[idx].keep;
        s_if.tuser = in_q[idx].user; s_if.tlast = in_q[idx].last; dis = in_q[idx].dis;
      end else begin
        s_if.tvalid = 1'b0;
      end
      m_if.tready = ($urandom_range(99) < rprob) && !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      if (s_if.tready !== (!m_if.tvalid || m_if.tready)) rdy_bad++;
      if (!s_if.tready) rdy_low++;
      if (m_if.tvalid && m_if.tready)
        obs.push_back('{m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast});
      if (s_if.tvalid && s_if.tready) begin model_push(in_q[idx]); idx++; end
      @(posedge clk); #1;
      cyc++;
    end
    s_if.tvalid = 1'b0; m_if.tready = 1'b1;
  endtask

  function automatic beat_t idle_beat(input bit d);
    return '{'0, {TK{1'b1}}, '0, 1'b0, d};
  endfunction

  function automatic beat_t com_beat(input bit last);
    return '{{4{32'h000000BC}}, 16'h1111, 16'h1111, last, 1'b0};
  endfunction

  task automatic test_reset();
    do_reset(1'b0);
    total++; if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_if.tvalid); end
    total++; if (m_if.tdata !== '0) begin bad++; $display("FAIL reset_data: got %h want 0", m_if.tdata); end
    total++; if ({m_if.tkeep, m_if.tuser, m_if.tlast} !== '0) begin bad++; $display("FAIL reset_side: got %h want 0", {m_if.tkeep, m_if.tuser, m_if.tlast}); end
    total++; if (s_if.tready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s_if.tready); end
    m_if.tready = 1'b1;
  endtask

  task automatic test_com_idle();
    bit to;
    beat_t b0;
    b0.data = {$urandom, $urandom, $urandom, 32'h0000_00BC};
    b0.keep = 16'h0003; b0.user = {12'($urandom), 4'h1}; b0.last = 1'b1; b0.dis = 1'b0;
    in_q.delete(); in_q.push_back(b0); in_q.push_back(idle_beat(0));
    run_stream(100, 100, -1, 0, to);
    total++; if (to) begin bad++; $display("FAIL com_idle_timeout: got %0d beats want 2", obs.size()); end
    if (obs.size() == 2) begin
      total++; if (obs[0] !== {b0.data, b0.keep, b0.user, b0.last}) begin bad++; $display("FAIL com_beat_pass: got %h want %h", obs[0].data, b0.data); end
      total++; if (obs[1].data !== {{3{32'h14C017FF}}, 32'hB214C017}) begin bad++; $display("FAIL com_idle_key: got %h want %h", obs[1].data, {{3{32'h14C017FF}}, 32'hB214C017}); end
      total++; if (obs[1] !== exp_q[1]) begin bad++; $display("FAIL com_idle_model: got %h want %h", obs[1].data, exp_q[1].data); end
    end
  endtask

  task automatic test_skp();
    bit to;
    in_q.delete();
    in_q.push_back('{{4{32'h1C1C1CBC}}, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0});
    in_q.push_back(idle_beat(0));
    run_stream(100, 100, -1, 0, to);
    total++; if (to) begin bad++; $display("FAIL skp_timeout: got %0d beats want 2", obs.size()); end
    if (obs.size() == 2) begin
      total++; if (obs[0].data !== {4{32'h1C1C1CBC}}) begin bad++; $display("FAIL skp_pass: got %h want %h", obs[0].data, {4{32'h1C1C1CBC}}); end
      total++; if (obs[1].data !== {4{32'h14C017FF}}) begin bad++; $display("FAIL skp_idle_key: got %h want %h", obs[1].data, {4{32'h14C017FF}}); end
    end
  endtask

  task automatic test_ts1();
    bit to;
    in_q.delete();
    for (int i = 0; i < 4; i++) begin
      beat_t bt;
      bt.data = {$urandom, $urandom, $urandom, $urandom};
      bt.keep = 16'hFFFF; bt.user = 16'h0; bt.last = (i == 3); bt.dis = 1'b0;
      if (i == 0) begin
        for (int l = 0; l < NL; l++) bt.data[l*32 +: 8] = 8'hBC;
        bt.user = 16'h1111;
      end
      in_q.push_back(bt);
    end
    in_q.push_back(idle_beat(0));
    run_stream(100, 100, -1, 0, to);
    total++; if (to) begin bad++; $display("FAIL ts1_timeout: got %0d beats want 5", obs.size()); end
    if (obs.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (obs[i].data !== in_q[i].data) begin bad++; $display("FAIL ts1_raw%0d: got %h want %h", i, obs[i].data, in_q[i].data); end
      end
      total++; if (obs[4] !== exp_q[4]) begin bad++; $display("FAIL ts1_next_key: got %h want %h", obs[4].data, exp_q[4].data); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    out_t ref_obs[$];
    in_q.delete();
    in_q.push_back(com_beat(1));
    for (int i = 0; i < 4; i++)
      in_q.push_back('{{$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 16'h0, 1'b0, 1'b0});
    run_stream(100, 100, -1, 0, to);
    ref_obs = obs;
    total++; if (to || rdy_low != 0) begin bad++; $display("FAIL nostall_run: got %0d beats ready_low=%0d want 5/0", obs.size(), rdy_low); end
    run_stream(100, 100, 2, 3, to);
    total++; if (to || obs.size() != 5) begin bad++; $display("FAIL stall_count: got %0d beats want 5", obs.size()); end
    total++; if (rdy_low != 3) begin bad++; $display("FAIL stall_ready_low: got %0d cycles want 3", rdy_low); end
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL stall_ready_rule: got %0d bad cycles want 0", rdy_bad); end
    for (int i = 0; i < 5 && i < obs.size() && i < ref_obs.size(); i++) begin
      total++; if (obs[i] !== ref_obs[i] || obs[i] !== exp_q[i]) begin bad++; $display("FAIL stall_beat%0d: got %h want %h", i, obs[i].data, exp_q[i].data); end
    end
  endtask

  task automatic test_scramble_dis();
    bit to;
    in_q.delete();
    in_q.push_back(com_beat(1)); in_q.push_back(idle_beat(1)); in_q.push_back(idle_beat(0));
    run_stream(100, 100, -1, 0, to);
    total++; if (to) begin bad++; $display("FAIL dis_timeout: got %0d beats want 3", obs.size()); end
    if (obs.size() == 3) begin
      total++; if (obs[1].data !== '0) begin bad++; $display("FAIL dis_raw: got %h want 0", obs[1].data); end
      total++; if (obs[2].data !== {4{32'h8202E7B2}}) begin bad++; $display("FAIL dis_resume: got %h want %h", obs[2].data, {4{32'h8202E7B2}}); end
    end
  endtask

  task automatic test_async_reset();
    bit to;
    s_if.tvalid = 1'b1; s_if.tdata = {4{32'h5A5A5A5A}}; s_if.tkeep = 16'hFFFF;
    s_if.tuser = 16'h0; s_if.tlast = 1'b1; dis = 1'b0; m_if.tready = 1'b0;
    @(posedge clk); #1 s_if.tvalid = 1'b0;
    @(negedge clk);
    total++; if (m_if.tvalid !== 1'b1) begin bad++; $display("FAIL held_valid: got %b want 1", m_if.tvalid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0) begin bad++; $display("FAIL async_clear: got valid=%b data=%h want 0", m_if.tvalid, m_if.tdata); end
    do_reset(1'b1);
    in_q.delete(); in_q.push_back(idle_beat(0));
    run_stream(100, 100, -1, 0, to);
    total++; if (to || obs.size() != 1) begin bad++; $display("FAIL post_reset_count: got %0d want 1", obs.size()); end
    else begin
      total++; if (obs[0].data !== {4{32'h14C017FF}}) begin bad++; $display("FAIL post_reset_seed: got %h want %h", obs[0].data, {4{32'h14C017FF}}); end
    end
  endtask

  task automatic test_random();
    bit to;
    int errs = 0;
    in_q.delete();
    for (int i = 0; i < 300; i++) begin
      beat_t bt;
      bt.data = {$urandom, $urandom, $urandom, $urandom};
      bt.keep = '0; bt.user = '0;
      for (int j = 0; j < TK; j++) begin
        int kind = $urandom_range(9);
        bt.keep[j] = ($urandom_range(99) < 85);
        if (kind == 0) begin bt.data[j*8 +: 8] = 8'hBC; bt.user[j] = 1'b1; end
        else if (kind == 1) begin bt.data[j*8 +: 8] = 8'h1C; bt.user[j] = 1'b1; end
        else if (kind == 2) begin bt.data[j*8 +: 8] = 8'hF7; bt.user[j] = 1'b1; end
      end
      bt.last = ($urandom_range(3) == 0);
      bt.dis = ($urandom_range(9) == 0);
      in_q.push_back(bt);
    end
    run_stream(70, 70, -1, 0, to);
    total++; if (to || obs.size() != 300) begin bad++; $display("FAIL rand_count: got %0d want 300", obs.size()); end
    total++; if (rdy_bad != 0) begin bad++; $display("FAIL rand_ready_rule: got %0d bad cycles want 0", rdy_bad); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i] !== exp_q[i]) begin
        bad++;
        if (errs < 5) $display("FAIL rand_beat%0d: got %h want %h", i, obs[i], exp_q[i]);
        errs++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_com_idle();
    test_skp();
    test_ts1();
    test_back_to_back();
    test_scramble_dis();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
